// File: rtl/adc_capture_ctrl_if.sv
// Signal bundle between the ADC capture sequencer and its surroundings: configuration,
// trigger and sample stream in, RAM write port and capture status out.
interface adc_capture_ctrl_if #(
    parameter int unsigned NUM_WORDS = 8192,
    parameter int unsigned ADDR_W    = $clog2(NUM_WORDS),
    parameter int unsigned SAMPLE_W  = 16
);
    logic                  cfg_arm;
    logic                  cfg_abort;
    logic                  cfg_ext_trig;
    logic [ADDR_W:0]       cfg_len;
    logic [7:0]            cfg_decim;
    logic                  trig_in;
    logic                  smp_vld;
    logic [SAMPLE_W-1:0]   smp_a;
    logic [SAMPLE_W-1:0]   smp_b;
    logic                  adc_we;
    logic [ADDR_W-1:0]     adc_addr;
    logic [2*SAMPLE_W-1:0] adc_data;
    logic                  busy;
    logic                  done;
    logic [ADDR_W-1:0]     trig_addr;
    logic [ADDR_W:0]       wr_count;

    modport master (
        output cfg_arm, cfg_abort, cfg_ext_trig, cfg_len, cfg_decim, trig_in,
        output smp_vld, smp_a, smp_b,
        input  adc_we, adc_addr, adc_data, busy, done, trig_addr, wr_count
    );

    modport slave (
        input  cfg_arm, cfg_abort, cfg_ext_trig, cfg_len, cfg_decim, trig_in,
        input  smp_vld, smp_a, smp_b,
        output adc_we, adc_addr, adc_data, busy, done, trig_addr, wr_count
    );
endinterface

// File: rtl/adc_capture_ctrl.sv
// Write-side sequencer for the ADC port of the sample RAM: decimates a two-channel sample
// stream, packs each pair into one word and writes it, with optional triggered capture.
module adc_capture_ctrl #(
    parameter int unsigned NUM_WORDS = 8192,
    parameter int unsigned ADDR_W    = $clog2(NUM_WORDS),
    parameter int unsigned SAMPLE_W  = 16
) (
    input logic               adc_clk,
    input logic               adc_rst,
    adc_capture_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDone} state_e;

    localparam logic [ADDR_W:0] LenMax = {1'b1, {ADDR_W{1'b0}}};

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     wptr_q, wptr_d;
    logic [ADDR_W-1:0]     trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [ADDR_W:0]       len_q, len_d;
    logic [ADDR_W:0]       wr_count_q, wr_count_d;
    logic [7:0]            decim_q, decim_d;
    logic [7:0]            dcnt_q, dcnt_d;
    logic [2*SAMPLE_W-1:0] data_q, data_d;
    logic                  we_q, we_d;
    logic                  done_q, done_d;
    logic                  trig_q;

    logic                  busy;
    logic                  arm_ok;
    logic                  trig_edge;
    logic                  accept;
    logic [ADDR_W:0]       count_inc;

    always_comb begin
        busy      = (state_q == StArmed) || (state_q == StCapture);
        arm_ok    = bus.cfg_arm && !bus.cfg_abort && !busy;
        trig_edge = bus.trig_in && !trig_q;
        // A sample landing in the abort cycle is dropped rather than written.
        accept    = bus.smp_vld && busy && (dcnt_q == '0) && !bus.cfg_abort;
        count_inc = wr_count_q + 1'b1;

        state_d     = state_q;
        wptr_d      = wptr_q;
        trig_addr_d = trig_addr_q;
        addr_d      = addr_q;
        len_d       = len_q;
        wr_count_d  = wr_count_q;
        decim_d     = decim_q;
        dcnt_d      = dcnt_q;
        data_d      = data_q;
        done_d      = done_q;
        we_d        = 1'b0;

        if (bus.cfg_abort) begin
            state_d = StIdle;
        end else if (arm_ok) begin
            len_d      = (bus.cfg_len == '0 || bus.cfg_len > LenMax) ? LenMax : bus.cfg_len;
            decim_d    = bus.cfg_decim;
            wptr_d     = '0;
            wr_count_d = '0;
            dcnt_d     = '0;
            done_d     = 1'b0;
            if (bus.cfg_ext_trig) begin
                state_d = StArmed;
            end else begin
                state_d     = StCapture;
                trig_addr_d = '0;
            end
        end else if (busy) begin
            if (bus.smp_vld) begin
                dcnt_d = (dcnt_q == '0) ? decim_q : dcnt_q - 8'd1;
            end
            if (accept) begin
                we_d   = 1'b1;
                addr_d = wptr_q;
                data_d = {bus.smp_b, bus.smp_a};
                wptr_d = wptr_q + 1'b1;
            end
            if (state_q == StArmed && trig_edge) begin
                state_d     = StCapture;
                trig_addr_d = wptr_q;
            end
            // The sample accepted alongside the trigger edge is the first post-trigger word.
            if (accept && (state_q == StCapture || trig_edge)) begin
                wr_count_d = count_inc;
                if (count_inc == len_q) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            state_q     <= StIdle;
            wptr_q      <= '0;
            trig_addr_q <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            wr_count_q  <= '0;
            decim_q     <= '0;
            dcnt_q      <= '0;
            data_q      <= '0;
            we_q        <= 1'b0;
            done_q      <= 1'b0;
            trig_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            trig_addr_q <= trig_addr_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            wr_count_q  <= wr_count_d;
            decim_q     <= decim_d;
            dcnt_q      <= dcnt_d;
            data_q      <= data_d;
            we_q        <= we_d;
            done_q      <= done_d;
            trig_q      <= bus.trig_in;
        end
    end

    assign bus.adc_we    = we_q;
    assign bus.adc_addr  = addr_q;
    assign bus.adc_data  = data_q;
    assign bus.busy      = busy;
    assign bus.done      = done_q;
    assign bus.trig_addr = trig_addr_q;
    assign bus.wr_count  = wr_count_q;
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench for adc_capture_ctrl: expected RAM writes are queued as samples are
// driven and matched by a monitor; status outputs are checked inline by each scenario task.
module tb_adc_capture_ctrl;
    localparam int unsigned NUM_WORDS = 8192;
    localparam int unsigned ADDR_W    = 13;

    logic adc_clk = 1'b0;
    logic adc_rst = 1'b1;

    int total = 0;
    int bad   = 0;

    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_data[$];

    adc_capture_ctrl_if #(.NUM_WORDS(NUM_WORDS)) bus ();

    adc_capture_ctrl #(.NUM_WORDS(NUM_WORDS)) dut (
        .adc_clk (adc_clk),
        .adc_rst (adc_rst),
        .bus     (bus)
    );

    always #5 adc_clk = ~adc_clk;

    // Scoreboard: every write strobe must match the oldest outstanding expectation.
    always @(negedge adc_clk) begin
        logic [ADDR_W-1:0] ea;
        logic [31:0]       ed;
        if (bus.adc_we === 1'b1) begin
            total++;
            if (exp_addr.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write addr=%0d data=%h, no write expected",
                         bus.adc_addr, bus.adc_data);
            end else begin
                ea = exp_addr.pop_front();
                ed = exp_data.pop_front();
                if (bus.adc_addr !== ea || bus.adc_data !== ed) begin
                    bad++;
                    $display("FAIL ram_write got addr=%0d data=%h, expected addr=%0d data=%h",
                             bus.adc_addr, bus.adc_data, ea, ed);
                end
            end
        end
    end

    task automatic step();
        @(posedge adc_clk);
        #1;
    endtask

    task automatic push(input int addr, input logic [31:0] data);
        exp_addr.push_back(ADDR_W'(addr));
        exp_data.push_back(data);
    endtask

    task automatic smp(input logic vld, input logic [15:0] a, input logic [15:0] b);
        bus.smp_vld = vld;
        bus.smp_a   = a;
        bus.smp_b   = b;
        step();
    endtask

    task automatic idle(input int n);
        bus.smp_vld = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic arm(input logic ext, input int len, input int decim);
        bus.cfg_ext_trig = ext;
        bus.cfg_len      = (ADDR_W + 1)'(len);
        bus.cfg_decim    = 8'(decim);
        bus.cfg_arm      = 1'b1;
        bus.smp_vld      = 1'b0;
        step();
        bus.cfg_arm = 1'b0;
    endtask

    task automatic drained(input string name);
        idle(2);
        total++;
        if (exp_addr.size() !== 0) begin
            bad++;
            $display("FAIL %s_writes_outstanding got=%0d expected=0", name, exp_addr.size());
        end
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic test_reset();
        adc_rst = 1'b1;
        idle(2);
        total++;
        if ({bus.adc_we, bus.busy, bus.done} !== 3'b000 || bus.adc_addr !== '0 ||
            bus.adc_data !== '0 || bus.trig_addr !== '0 || bus.wr_count !== '0) begin
            bad++;
            $display("FAIL reset_outputs got we=%b busy=%b done=%b addr=%0d data=%h ta=%0d wc=%0d, expected all 0",
                     bus.adc_we, bus.busy, bus.done, bus.adc_addr, bus.adc_data,
                     bus.trig_addr, bus.wr_count);
        end
        adc_rst = 1'b0;
        idle(1);
    endtask

    task automatic test_immediate();
        arm(1'b0, 4, 0);
        for (int i = 1; i <= 6; i++) begin
            if (i <= 4) push(i - 1, {16'(16'h100 + i), 16'(i)});
            smp(1'b1, 16'(i), 16'(16'h100 + i));
            if (i == 4) begin
                total++;
                if ({bus.adc_we, bus.done, bus.busy} !== 3'b110) begin
                    bad++;
                    $display("FAIL imm_done_with_last_write got we/done/busy=%b%b%b expected 110",
                             bus.adc_we, bus.done, bus.busy);
                end
            end
        end
        drained("imm");
        total++;
        if (bus.wr_count !== 14'd4 || bus.done !== 1'b1) begin
            bad++;
            $display("FAIL imm_status got wc=%0d done=%b expected wc=4 done=1",
                     bus.wr_count, bus.done);
        end
    endtask

    task automatic test_decim();
        arm(1'b0, 3, 2);
        for (int i = 0; i <= 8; i++) begin
            if (i % 3 == 0) push(i / 3, {16'(16'h200 + i), 16'(i)});
            smp(1'b1, 16'(i), 16'(16'h200 + i));
            if (i % 2 == 1) smp(1'b0, 16'hdead, 16'hbeef);
        end
        drained("decim");
        total++;
        if (bus.wr_count !== 14'd3 || bus.done !== 1'b1) begin
            bad++;
            $display("FAIL decim_status got wc=%0d done=%b expected wc=3 done=1",
                     bus.wr_count, bus.done);
        end
    endtask

    task automatic test_ext_trig();
        bus.trig_in = 1'b0;
        arm(1'b1, 2, 0);
        for (int i = 0; i < 10; i++) begin
            push(i, {16'(16'h300 + i), 16'(i)});
            smp(1'b1, 16'(i), 16'(16'h300 + i));
        end
        total++;
        if (bus.busy !== 1'b1 || bus.wr_count !== '0) begin
            bad++;
            $display("FAIL ext_pretrig got busy=%b wc=%0d expected busy=1 wc=0",
                     bus.busy, bus.wr_count);
        end
        bus.trig_in = 1'b1;
        push(10, {16'h030a, 16'd10});
        smp(1'b1, 16'd10, 16'h030a);
        total++;
        if (bus.trig_addr !== 13'd10 || bus.wr_count !== 14'd1 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL ext_trig_edge got ta=%0d wc=%0d busy=%b expected ta=10 wc=1 busy=1",
                     bus.trig_addr, bus.wr_count, bus.busy);
        end
        push(11, {16'h030b, 16'd11});
        smp(1'b1, 16'd11, 16'h030b);
        total++;
        if (bus.done !== 1'b1 || bus.wr_count !== 14'd2) begin
            bad++;
            $display("FAIL ext_done got done=%b wc=%0d expected done=1 wc=2",
                     bus.done, bus.wr_count);
        end
        bus.trig_in = 1'b0;
        drained("ext");
    endtask

    task automatic test_abort();
        arm(1'b0, 5, 0);
        push(0, 32'h0400_0000);
        smp(1'b1, 16'h0000, 16'h0400);
        push(1, 32'h0401_0001);
        smp(1'b1, 16'h0001, 16'h0401);
        bus.cfg_abort = 1'b1;
        bus.cfg_arm   = 1'b1;
        smp(1'b1, 16'h0002, 16'h0402);
        bus.cfg_abort = 1'b0;
        bus.cfg_arm   = 1'b0;
        total++;
        if ({bus.adc_we, bus.busy, bus.done} !== 3'b000 || bus.wr_count !== 14'd2) begin
            bad++;
            $display("FAIL abort_status got we=%b busy=%b done=%b wc=%0d expected 0/0/0 wc=2",
                     bus.adc_we, bus.busy, bus.done, bus.wr_count);
        end
        smp(1'b1, 16'h0003, 16'h0403);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_arm_ignored got busy=%b expected 0", bus.busy);
        end
        drained("abort");
    endtask

    task automatic test_arm_busy();
        bus.trig_in = 1'b1;
        idle(1);
        arm(1'b1, 2, 0);
        for (int i = 0; i < 3; i++) begin
            push(i, {16'(16'h500 + i), 16'(i)});
            smp(1'b1, 16'(i), 16'(16'h500 + i));
        end
        bus.cfg_arm = 1'b1;
        push(3, 32'h0503_0003);
        smp(1'b1, 16'd3, 16'h0503);
        bus.cfg_arm = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || bus.wr_count !== '0) begin
            bad++;
            $display("FAIL held_trig_no_fire got busy=%b wc=%0d expected busy=1 wc=0",
                     bus.busy, bus.wr_count);
        end
        bus.trig_in = 1'b0;
        push(4, 32'h0504_0004);
        smp(1'b1, 16'd4, 16'h0504);
        bus.trig_in = 1'b1;
        push(5, 32'h0505_0005);
        smp(1'b1, 16'd5, 16'h0505);
        total++;
        if (bus.trig_addr !== 13'd5 || bus.wr_count !== 14'd1) begin
            bad++;
            $display("FAIL rearm_trig got ta=%0d wc=%0d expected ta=5 wc=1",
                     bus.trig_addr, bus.wr_count);
        end
        push(6, 32'h0506_0006);
        smp(1'b1, 16'd6, 16'h0506);
        total++;
        if (bus.done !== 1'b1 || bus.wr_count !== 14'd2) begin
            bad++;
            $display("FAIL arm_busy_done got done=%b wc=%0d expected done=1 wc=2",
                     bus.done, bus.wr_count);
        end
        bus.trig_in = 1'b0;
        drained("arm_busy");
    endtask

    task automatic test_wrap();
        bus.trig_in = 1'b0;
        arm(1'b1, 0, 0);
        for (int i = 0; i < NUM_WORDS + NUM_WORDS + 3; i++) begin
            bus.trig_in = (i == NUM_WORDS + 3);
            push(i % NUM_WORDS, {~16'(i), 16'(i)});
            smp(1'b1, 16'(i), ~16'(i));
            if (i == NUM_WORDS + 3) begin
                total++;
                if (bus.trig_addr !== 13'd3) begin
                    bad++;
                    $display("FAIL wrap_trig_addr got=%0d expected=3", bus.trig_addr);
                end
            end
        end
        bus.trig_in = 1'b0;
        total++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.wr_count !== 14'd8192) begin
            bad++;
            $display("FAIL wrap_done got done=%b busy=%b wc=%0d expected done=1 busy=0 wc=8192",
                     bus.done, bus.busy, bus.wr_count);
        end
        drained("wrap");
    endtask

    task automatic test_reset_mid();
        arm(1'b1, 8, 0);
        for (int i = 0; i < 5; i++) begin
            bus.trig_in = (i == 3);
            push(i, {16'(16'h700 + i), 16'(i)});
            smp(1'b1, 16'(i), 16'(16'h700 + i));
        end
        bus.trig_in = 1'b0;
        adc_rst = 1'b1;
        smp(1'b1, 16'd5, 16'h0705);
        total++;
        if ({bus.adc_we, bus.busy, bus.done} !== 3'b000 || bus.adc_addr !== '0 ||
            bus.adc_data !== '0 || bus.trig_addr !== '0 || bus.wr_count !== '0) begin
            bad++;
            $display("FAIL mid_reset got we=%b busy=%b done=%b addr=%0d data=%h ta=%0d wc=%0d, expected all 0",
                     bus.adc_we, bus.busy, bus.done, bus.adc_addr, bus.adc_data,
                     bus.trig_addr, bus.wr_count);
        end
        adc_rst = 1'b0;
        drained("mid_reset");
    endtask

    initial begin
        bus.cfg_arm      = 1'b0;
        bus.cfg_abort    = 1'b0;
        bus.cfg_ext_trig = 1'b0;
        bus.cfg_len      = '0;
        bus.cfg_decim    = '0;
        bus.trig_in      = 1'b0;
        bus.smp_vld      = 1'b0;
        bus.smp_a        = '0;
        bus.smp_b        = '0;
        test_reset();
        test_immediate();
        test_decim();
        test_ext_trig();
        test_abort();
        test_arm_busy();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
